// File: rtl/ps2_scancode_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM encoding, prefix bytes and frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;
  localparam int         PS2_DATA_BITS    = PS2_FRAME_BITS - 3;

  // Odd parity over data plus parity bit means the XOR of all nine is 1.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Decoded key-event bundle from the PS/2 receiver to the digit-entry stage.
interface ps2_scancode_rx_if;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT;
  logic       KEY_RELEASE;
  logic       KEY_VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;

  modport master (output KEY_CODE, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR);
  modport slave  (input  KEY_CODE, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers on PS2 clock/data, debounce on the clock line,
// and a one-cycle strobe on each falling edge of the filtered clock.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_raw,
  input  logic ps2_dat_raw,
  output logic strobe,
  output logic dat_bit
);

  localparam int CW = $clog2(FILTER_LEN);

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    clk_meta_d = ps2_clk_raw;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_dat_raw;
    dat_sync_d = dat_meta_q;
    filt_d     = filt_q;
    cnt_d      = '0;
    // Count consecutive samples disagreeing with the filtered level; flip on the FILTER_LEN-th.
    if (clk_sync_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
      else                              cnt_d  = cnt_q + 1'b1;
    end
    strobe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
    end
  end

  assign strobe  = strobe_q;
  assign dat_bit = dat_sync_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames and checks bytes, folds E0/F0 prefixes into
// single make/break key events with one-cycle valid/error pulses.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic               PS2Clk,
  input  logic               PS2Data,
  ps2_scancode_rx_if.master  key
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic strobe, dat_bit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (CLK),
    .rst_n      (RST_N),
    .ps2_clk_raw(PS2Clk),
    .ps2_dat_raw(PS2Data),
    .strobe     (strobe),
    .dat_bit    (dat_bit)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d;
  logic          kext_q, kext_d, krel_q, krel_d;
  logic          kvld_q, kvld_d, perr_q, perr_d, ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    par_d      = par_q;
    tmo_d      = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    kext_d     = kext_q;
    krel_d     = krel_q;
    kvld_d     = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (!ENABLE) begin
      state_d    = ST_IDLE;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          byte_d    = {dat_bit, byte_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_bit;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_bit || !ps2_parity_ok(byte_q, par_q)) begin
            ferr_d     = ~dat_bit;
            perr_d     = dat_bit;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else if (byte_q == PS2_PREFIX_EXT) begin
            ext_pend_d = 1'b1;
          end else if (byte_q == PS2_PREFIX_BREAK) begin
            brk_pend_d = 1'b1;
          end else begin
            code_d     = byte_q;
            kext_d     = ext_pend_q;
            krel_d     = brk_pend_q;
            kvld_d     = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Keyboard stalled mid-frame: abandon it once the idle budget is spent.
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        ferr_d     = 1'b1;
        state_d    = ST_IDLE;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      kext_q     <= 1'b0;
      krel_q     <= 1'b0;
      kvld_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      krel_q     <= krel_d;
      kvld_q     <= kvld_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign key.KEY_CODE    = code_q;
  assign key.KEY_EXT     = kext_q;
  assign key.KEY_RELEASE = krel_q;
  assign key.KEY_VALID   = kvld_q;
  assign key.PARITY_ERR  = perr_q;
  assign key.FRAME_ERR   = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed plus randomized frames against a byte-level model of prefix folding and error rules.
module tb_ps2_scancode_rx;

  localparam int FILT = 8;
  localparam int TMO  = 600;
  localparam int HALF = 40;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic ENABLE = 1'b1;
  logic PS2Clk = 1'b1;
  logic PS2Data = 1'b1;

  ps2_scancode_rx_if key_if ();

  ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ENABLE (ENABLE),
    .PS2Clk (PS2Clk),
    .PS2Data(PS2Data),
    .key    (key_if)
  );

  always #5 CLK = ~CLK;

  int nv = 0, np = 0, nf = 0, nmulti = 0;
  always @(negedge CLK) begin
    if (key_if.KEY_VALID)  nv++;
    if (key_if.PARITY_ERR) np++;
    if (key_if.FRAME_ERR)  nf++;
    if (int'(key_if.KEY_VALID) + int'(key_if.PARITY_ERR) + int'(key_if.FRAME_ERR) > 1) nmulti++;
  end

  int errors = 0;
  int checks = 0;

  // Reference state: pending prefixes and the event downstream should currently hold.
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] e_code = 8'h00;
  logic       e_ext = 1'b0, e_rel = 1'b0;
  int         e_dv, e_dp, e_df;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model(input logic [7:0] b, input bit pbad, input bit sbad);
    e_dv = 0; e_dp = 0; e_df = 0;
    if (sbad) begin
      e_df = 1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (pbad) begin
      e_dp = 1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e_dv = 1; e_code = b; e_ext = m_ext; e_rel = m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pbad, input bit sbad,
                            input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {~sbad, (~^b) ^ pbad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2Data = bits[i];
      wait_cyc(HALF);
      PS2Clk = 1'b0;
      wait_cyc(HALF);
      PS2Clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(15);
        PS2Clk = 1'b0;
        wait_cyc(FILT - 1);
        PS2Clk = 1'b1;
        wait_cyc(15);
      end
    end
    PS2Data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " KEY_CODE"}, 32'(key_if.KEY_CODE), 32'(e_code));
    chk({tag, " KEY_EXT"}, 32'(key_if.KEY_EXT), 32'(e_ext));
    chk({tag, " KEY_RELEASE"}, 32'(key_if.KEY_RELEASE), 32'(e_rel));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit pbad,
                          input bit sbad, input int glitch_at);
    int v0, p0, f0;
    v0 = nv; p0 = np; f0 = nf;
    model(b, pbad, sbad);
    send_frame(b, pbad, sbad, 11, glitch_at);
    chk({tag, " valid pulses"}, 32'(nv - v0), 32'(e_dv));
    chk({tag, " parity pulses"}, 32'(np - p0), 32'(e_dp));
    chk({tag, " frame pulses"}, 32'(nf - f0), 32'(e_df));
    check_outputs(tag);
  endtask

  initial begin
    int v0, p0, f0;
    logic [7:0] rb;
    bit rp, rs;

    wait_cyc(5);
    chk("reset KEY_CODE", 32'(key_if.KEY_CODE), 32'h0);
    chk("reset flags", 32'({key_if.KEY_EXT, key_if.KEY_RELEASE, key_if.KEY_VALID,
                            key_if.PARITY_ERR, key_if.FRAME_ERR}), 32'h0);
    RST_N = 1'b1;
    wait_cyc(20);

    do_frame("make16", 8'h16, 0, 0, -1);
    do_frame("brkF0", 8'hF0, 0, 0, -1);
    do_frame("brk16", 8'h16, 0, 0, -1);
    do_frame("extE0", 8'hE0, 0, 0, -1);
    do_frame("extF0", 8'hF0, 0, 0, -1);
    do_frame("ext75", 8'h75, 0, 0, -1);
    do_frame("preE0", 8'hE0, 0, 0, -1);
    do_frame("par1E", 8'h1E, 1, 0, -1);
    do_frame("postF0", 8'hF0, 0, 0, -1);
    do_frame("post1E", 8'h1E, 0, 0, -1);
    do_frame("stop0", 8'h55, 0, 1, -1);

    // Stall after four data bits.
    v0 = nv; p0 = np; f0 = nf;
    send_frame(8'h0F, 0, 0, 5, -1);
    wait_cyc(TMO + 100);
    m_ext = 1'b0; m_brk = 1'b0;
    chk("timeout frame pulses", 32'(nf - f0), 32'd1);
    chk("timeout valid pulses", 32'(nv - v0), 32'd0);
    chk("timeout parity pulses", 32'(np - p0), 32'd0);
    check_outputs("timeout");
    do_frame("after45", 8'h45, 0, 0, -1);

    do_frame("glitch26", 8'h26, 0, 0, 4);

    // Reset mid-frame with an extension prefix pending.
    do_frame("rstE0", 8'hE0, 0, 0, -1);
    send_frame(8'h3D, 0, 0, 4, -1);
    RST_N = 1'b0;
    wait_cyc(1);
    RST_N = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; e_code = 8'h00; e_ext = 1'b0; e_rel = 1'b0;
    check_outputs("midreset");
    wait_cyc(20);
    do_frame("after3D", 8'h3D, 0, 0, -1);

    // Disabled receiver: nothing comes out and the pending prefix is dropped.
    do_frame("enE0", 8'hE0, 0, 0, -1);
    ENABLE = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    v0 = nv; p0 = np; f0 = nf;
    send_frame(8'h1C, 0, 0, 11, -1);
    chk("disabled pulses", 32'((nv - v0) + (np - p0) + (nf - f0)), 32'd0);
    check_outputs("disabled");
    ENABLE = 1'b1;
    wait_cyc(10);
    do_frame("reen1C", 8'h1C, 0, 0, -1);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rp = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 9) == 0);
      do_frame($sformatf("rand%0d", i), rb, rp, rs, -1);
    end

    chk("exclusive pulses", 32'(nmulti), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
